// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - initiator that drives a bank of JK flip-flops to a target word
//
// Accepts a target word over a valid/ready handshake, derives per-bit J/K
// excitations from the bank's Qout feedback, pulses CE for one cycle and then
// verifies the bank against the target, retrying a bounded number of times.
//
// Ports:
//   Clk        clock, rising edge
//   R          synchronous reset, active-high
//   tgt_valid  target word offered
//   tgt_data   desired next bank value
//   tgt_toggle excitation mode (1 = toggle differing bits, 0 = set/reset)
//   tgt_ready  controller idle and able to accept a target
//   q_fb       Qout vector of the driven bank
//   J, K       excitation to the bank
//   CE         clock enable to the bank, one cycle per DRIVE
//   busy       high in DRIVE or CHECK
//   done       one-cycle pulse, update verified
//   err        one-cycle pulse, update failed after retries
//   err_cnt    saturating count of err pulses
module jk_bank_driver #(
    parameter int WIDTH   = 4,
    parameter int RETRIES = 2,
    parameter int ERR_W   = 8
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             tgt_toggle,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             CE,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  tgt_reg;
    logic              mode_reg;
    logic [RW-1:0]     retry_cnt;
    logic [WIDTH-1:0]  diff;

    assign diff      = q_fb ^ tgt_reg;
    assign tgt_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge Clk) begin
        if (R) begin
            state     <= S_IDLE;
            tgt_reg   <= '0;
            mode_reg  <= 1'b0;
            retry_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tgt_valid) begin
                        tgt_reg   <= tgt_data;
                        mode_reg  <= tgt_toggle;
                        retry_cnt <= '0;
                        state     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (q_fb == tgt_reg) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else if (retry_cnt < RETRY_MAX) begin
                        retry_cnt <= retry_cnt + RW'(1);
                        state     <= S_DRIVE;
                    end else begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                        if (err_cnt != {ERR_W{1'b1}}) begin
                            err_cnt <= err_cnt + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Excitation is combinational from live feedback so a retry re-targets
    // only the bits still wrong. R masks the bank interface in every state.
    always_comb begin
        J  = '0;
        K  = '0;
        CE = 1'b0;
        if (!R && state == S_DRIVE) begin
            CE = 1'b1;
            if (mode_reg) begin
                J = diff;
                K = diff;
            end else begin
                J = diff & tgt_reg;
                K = diff & ~tgt_reg;
            end
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb/tb_jk_bank_driver.sv - self-checking bench for jk_bank_driver with a behavioural JK bank
module tb_jk_bank_driver;

    localparam int W     = 4;
    localparam int RT    = 2;
    localparam int EW    = 2;
    localparam int CMAX  = (1 << EW) - 1;

    logic          Clk = 1'b0;
    logic          R;
    logic          tgt_valid;
    logic [W-1:0]  tgt_data;
    logic          tgt_toggle;
    logic          tgt_ready;
    logic [W-1:0]  q_fb;
    logic [W-1:0]  J;
    logic [W-1:0]  K;
    logic          CE;
    logic          busy;
    logic          done;
    logic          err;
    logic [EW-1:0] err_cnt;

    always #5 Clk = ~Clk;

    jk_bank_driver #(.WIDTH(W), .RETRIES(RT), .ERR_W(EW)) dut (
        .Clk        (Clk),
        .R          (R),
        .tgt_valid  (tgt_valid),
        .tgt_data   (tgt_data),
        .tgt_toggle (tgt_toggle),
        .tgt_ready  (tgt_ready),
        .q_fb       (q_fb),
        .J          (J),
        .K          (K),
        .CE         (CE),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    // Behavioural JK bank; s0/s1 force observed bits stuck at 0/1.
    logic [W-1:0] bank_q;
    logic [W-1:0] s0, s1, ld_val;
    logic         ld;

    assign q_fb = (bank_q & ~s0) | s1;

    always @(posedge Clk) begin
        if (ld) begin
            bank_q <= ld_val;
        end else if (CE) begin
            for (int i = 0; i < W; i++) begin
                case ({J[i], K[i]})
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] force_q(input logic [W-1:0] v);
        return (v & ~s0) | s1;
    endfunction

    task automatic load_bank(input logic [W-1:0] v);
        @(negedge Clk);
        ld     = 1'b1;
        ld_val = v;
        @(negedge Clk);
        ld     = 1'b0;
    endtask

    // Offers one target at the current negedge and checks every cycle until
    // the controller returns to idle. With a healthy bank one drive suffices;
    // a stuck bit makes every drive fail, so RT+1 drives then err.
    task automatic run_txn(input logic [W-1:0] tgt, input logic tog);
        logic [W-1:0] qs, fin, qcur, ej, ek;
        int  nd, last;
        bit  ok, drv;
        qs   = force_q(bank_q);
        fin  = force_q(tgt);
        ok   = (fin == tgt);
        nd   = ok ? 1 : RT + 1;
        last = 2 * nd + 1;
        tgt_valid  = 1'b1;
        tgt_data   = tgt;
        tgt_toggle = tog;
        chk("ready_before", tgt_ready, 1);
        for (int c = 1; c <= last; c++) begin
            @(negedge Clk);
            if (c == 1) begin
                tgt_valid  = 1'b0;
                tgt_data   = W'($urandom);
                tgt_toggle = 1'($urandom);
            end
            drv  = (c % 2 == 1) && (c < last);
            qcur = (c == 1) ? qs : fin;
            ej = '0;
            ek = '0;
            if (drv) begin
                for (int i = 0; i < W; i++) begin
                    if (qcur[i] != tgt[i]) begin
                        if (tog) begin
                            ej[i] = 1'b1;
                            ek[i] = 1'b1;
                        end else if (tgt[i]) begin
                            ej[i] = 1'b1;
                        end else begin
                            ek[i] = 1'b1;
                        end
                    end
                end
            end
            if (c == last && !ok && exp_cnt < CMAX) exp_cnt++;
            chk("ce", CE, drv);
            chk("j", J, ej);
            chk("k", K, ek);
            chk("busy", busy, c < last);
            chk("ready", tgt_ready, c == last);
            chk("done", done, ok && c == last);
            chk("err", err, !ok && c == last);
        end
        chk("q_final", q_fb, fin);
        chk("err_cnt", err_cnt, exp_cnt);
    endtask

    initial begin
        R          = 1'b1;
        tgt_valid  = 1'b0;
        tgt_data   = '0;
        tgt_toggle = 1'b0;
        s0         = '0;
        s1         = '0;
        ld         = 1'b1;
        ld_val     = '0;
        repeat (3) @(negedge Clk);
        chk("rst_ce", CE, 0);
        chk("rst_jk", {J, K}, 0);
        ld = 1'b0;
        R  = 1'b0;
        @(negedge Clk);
        chk("rst_ready", tgt_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // Directed cases
        load_bank(4'b0000);
        run_txn(4'b1010, 1'b0);
        load_bank(4'b1100);
        run_txn(4'b0110, 1'b1);
        load_bank(4'b0101);
        run_txn(4'b0101, 1'b0);
        load_bank(4'b0000);
        s0 = 4'b0001;
        run_txn(4'b0001, 1'b0);
        chk("err_cnt_one", err_cnt, 1);
        s0 = '0;

        // Back-to-back with tgt_valid held high
        load_bank(4'b0000);
        tgt_valid  = 1'b1;
        tgt_data   = 4'b0001;
        tgt_toggle = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge Clk);
            chk("b2b_done", done, c % 3 == 0);
            chk("b2b_ready", tgt_ready, c % 3 == 0);
            if (c == 3) tgt_data = 4'b0010;
            if (c == 6) tgt_data = 4'b0011;
            if (c == 9) tgt_valid = 1'b0;
        end
        chk("b2b_q", q_fb, 4'b0011);

        // Reset during DRIVE: bank interface must be masked and the bank untouched
        load_bank(4'b0000);
        tgt_valid = 1'b1;
        tgt_data  = 4'b1111;
        @(negedge Clk);
        tgt_valid = 1'b0;
        R = 1'b1;
        #1;
        chk("rstd_ce", CE, 0);
        chk("rstd_jk", {J, K}, 0);
        @(negedge Clk);
        R = 1'b0;
        exp_cnt = 0;
        chk("rstd_ready", tgt_ready, 1);
        chk("rstd_done_err", {done, err}, 0);
        chk("rstd_err_cnt", err_cnt, 0);
        chk("rstd_q", q_fb, 4'b0000);

        // Reset during CHECK: transaction dropped, no done/err afterwards
        tgt_valid = 1'b1;
        tgt_data  = 4'b0110;
        @(negedge Clk);
        tgt_valid = 1'b0;
        @(negedge Clk);
        R = 1'b1;
        #1;
        chk("rstc_ce", CE, 0);
        chk("rstc_jk", {J, K}, 0);
        @(negedge Clk);
        R = 1'b0;
        chk("rstc_ready", tgt_ready, 1);
        chk("rstc_done_err", {done, err}, 0);
        @(negedge Clk);
        chk("rstc_done_err2", {done, err}, 0);
        chk("rstc_err_cnt", err_cnt, 0);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            s0 = '0;
            s1 = '0;
            if ($urandom_range(0, 3) == 0) begin
                int b;
                b = $urandom_range(0, W - 1);
                if ($urandom_range(0, 1) == 1) s0[b] = 1'b1;
                else s1[b] = 1'b1;
            end
            if ($urandom_range(0, 2) == 0) load_bank(W'($urandom));
            run_txn(W'($urandom), 1'($urandom));
        end

        // Saturation of the error counter
        s0 = 4'b0001;
        s1 = '0;
        for (int n = 0; n < 5; n++) begin
            run_txn(4'b0001, 1'b0);
        end
        chk("err_cnt_sat", err_cnt, CMAX);
        s0 = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Initiator/controller for a bank of WIDTH synchronous JK flip-flops (each with J, K, CE inputs and a Qout output).
- Accepts a target word over a valid/ready handshake and derives per-bit J/K excitations from the bank's current Qout feedback. It pulses CE for one cycle, then checks the bank output against the target.
- Retries a mismatching update a bounded number of times, then flags an error. Sits between the sequencing logic (counters, FSMs) and the flip-flop bank it drives.

Parameters:
- WIDTH, 4, number of flip-flops driven (J/K/q_fb width).
- RETRIES, 2, extra DRIVE attempts after a failed CHECK before declaring error (0 = no retry).
- ERR_W, 8, width of the saturating error counter.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- R  input  1  synchronous reset, active-high.
- tgt_valid  input  1  target word offered.
- tgt_data  input  WIDTH  desired next bank value.
- tgt_toggle  input  1  excitation mode; sampled with tgt_data at the handshake.
- tgt_ready  output  1  controller can accept a target.
- q_fb  input  WIDTH  Qout vector of the driven bank.
- J  output  WIDTH  J inputs to the bank.
- K  output  WIDTH  K inputs to the bank.
- CE  output  1  clock enable to all bank flip-flops.
- busy  output  1  high in DRIVE or CHECK.
- done  output  1  one-cycle pulse: update verified.
- err  output  1  one-cycle pulse: update failed after retries.
- err_cnt  output  ERR_W  count of err pulses; saturates at all-ones.

Behaviour:
- Reset, when R=1 at an edge:
  - state goes to IDLE; tgt_reg, mode_reg, retry counter, done, err and err_cnt clear to 0.
  - While R=1, J, K and CE are forced to 0 combinationally, whatever the state.
  - R has priority over every other event, including a reset arriving mid-DRIVE or mid-CHECK; the transaction is dropped with no done or err.
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - tgt_ready=1, busy=0; J=K=0, CE=0.
  - When tgt_valid & tgt_ready at an edge: capture tgt_data into tgt_reg and tgt_toggle into mode_reg, clear the retry counter, go to DRIVE.
- DRIVE, exactly one cycle:
  - tgt_ready=0, busy=1, CE=1.
  - J/K are combinational from q_fb and tgt_reg, per bit i:
    - q_fb[i]==tgt_reg[i]: J=0, K=0 (hold).
    - differing bit, mode_reg=0: 0->1 gives J=1, K=0; 1->0 gives J=0, K=1.
    - differing bit, mode_reg=1: J=1, K=1 (toggle).
  - If q_fb already equals tgt_reg, CE is still 1 with all J=K=0.
  - Next state is CHECK.
- CHECK, one cycle:
  - CE=0, J=K=0, busy=1.
  - Compare q_fb with tgt_reg:
    - match: go to IDLE; done=1 in the next cycle.
    - mismatch and retry counter < RETRIES: increment the counter, go to DRIVE (J/K recomputed from the new q_fb).
    - mismatch and counter == RETRIES: go to IDLE; err=1 in the next cycle; err_cnt increments unless already all-ones.
- Latency: handshake at the end of cycle 0 gives DRIVE in cycle 1, CHECK in cycle 2, and done plus tgt_ready=1 in cycle 3. Each retry adds 2 cycles.
- done and err are registered, never both high, and last one cycle.
- Back-to-back: a target offered in the cycle done is high is accepted, so the next DRIVE follows in the cycle after.
- tgt_valid is ignored while busy; the source must hold tgt_valid/tgt_data until accepted.
- Changes on tgt_data/tgt_toggle after capture have no effect on the transaction.
- q_fb is assumed to be the registered Qout of a bank clocked by Clk. The bank's own reset/set are outside this block.

Test Plan:
(Bench instantiates a behavioural WIDTH=4 JK bank fed by J/K/CE and returning q_fb; "stuck" forcing applies to this bank.)
- Basic update: bank=0000, send 1010 (toggle=0) -> cycle 1 shows CE=1, J=1010, K=0000; cycle 3 done=1, q_fb=1010, err_cnt=0.
- Toggle mode: bank=1100, send 0110 (toggle=1) -> DRIVE shows J=K=1010; done in cycle 3, q_fb=0110.
- No-change target: bank=0101, send 0101 -> DRIVE shows CE=1, J=K=0000; done in cycle 3.
- Retry/error: force bank bit 0 stuck at 0, RETRIES=2, send 0001 -> three DRIVE pulses at cycles 1, 3 and 5; err=1 in cycle 7; err_cnt=1; no done.
- Reset mid-operation: assert R during CHECK -> next cycle state IDLE, tgt_ready=1, no done/err; J, K and CE are 0 throughout the R cycle; err_cnt=0.
- Back-to-back and saturation: stream 0001, 0010, 0011 with tgt_valid held high -> done at cycles 3, 6 and 9. With ERR_W=2, 5 forced failures -> err_cnt holds at 11.
